// File: rtl/reg_alias_file.sv
`default_nettype none
// ============================================================================
// reg_alias_file : 32 x DATA_W architectural register file with per-register
//                  ROB alias tags (rename state). Optional: COMMIT_FORWARD_EN.
// Revision       : 1.0
// ============================================================================
module reg_alias_file #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback,
  input  logic [4:0]          rs1_idx,
  input  logic [4:0]          rs2_idx,
  output logic                rs1_busy,
  output logic [ROB_ID_W-1:0] rs1_alias,
  output logic [DATA_W-1:0]   rs1_val,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs2_alias,
  output logic [DATA_W-1:0]   rs2_val,
  input  logic                rename_en,
  input  logic [4:0]          rename_rd,
  input  logic [ROB_ID_W-1:0] rename_id,
  input  logic                commit_en,
  input  logic [4:0]          commit_rd,
  input  logic [DATA_W-1:0]   commit_val,
  input  logic [ROB_ID_W-1:0] commit_alias
);

  localparam int IDX_W = 5;

  logic [DATA_W-1:0]   val_q   [REG_NUM];
  logic [ROB_ID_W-1:0] alias_q [REG_NUM];

  logic commit_hit;
  logic commit_clear;
  logic rename_hit;

  assign commit_hit   = commit_en && (commit_rd != '0);
  assign commit_clear = commit_hit && (alias_q[commit_rd] == commit_alias);
  assign rename_hit   = rename_en && (rename_rd != '0) && !rollback;

  // x0 is never written, so its flops stay at their reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]   <= '0;
        alias_q[i] <= '0;
      end
    end else if (rdy) begin
      if (commit_hit) begin
        val_q[commit_rd] <= commit_val;
      end
      if (rollback) begin
        for (int i = 0; i < REG_NUM; i++) begin
          alias_q[i] <= '0;
        end
      end else begin
        if (commit_clear) begin
          alias_q[commit_rd] <= '0;
        end
        // Later assignment wins: a same-cycle rename keeps ownership of rd.
        if (rename_hit) begin
          alias_q[rename_rd] <= rename_id;
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_query
    logic [IDX_W-1:0]    idx;
    logic                fwd;
    logic                busy;
    logic [ROB_ID_W-1:0] alias_id;
    logic [DATA_W-1:0]   val;

    assign idx = (p == 0) ? rs1_idx : rs2_idx;

`ifdef COMMIT_FORWARD_EN
    assign fwd = commit_hit && (commit_rd == idx) &&
                 (alias_q[idx] == commit_alias) && !rollback;
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
      busy     = 1'b0;
      alias_id = '0;
      val      = '0;
      if (idx != '0) begin
        if (fwd) begin
          val = commit_val;
        end else begin
          busy     = (alias_q[idx] != '0);
          alias_id = alias_q[idx];
          val      = val_q[idx];
        end
      end
    end
  end

  assign rs1_busy  = g_query[0].busy;
  assign rs1_alias = g_query[0].alias_id;
  assign rs1_val   = g_query[0].val;
  assign rs2_busy  = g_query[1].busy;
  assign rs2_alias = g_query[1].alias_id;
  assign rs2_val   = g_query[1].val;

  // Alias 0 means "no alias", so the dispatcher must never rename with it.
  a_rename_id_nonzero : assert property (
    @(posedge clk) disable iff (!rst_n)
      (rdy && rename_hit) |-> (rename_id != '0)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_alias_file.sv
`default_nettype none
// ============================================================================
// tb_reg_alias_file : randomized + directed bench for reg_alias_file against
//                     an array-based reference model. Revision 1.0
// ============================================================================
module tb_reg_alias_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        rollback;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_alias, rs2_alias;
  logic [31:0] rs1_val, rs2_val;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_id;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_alias;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] m_val   [32];
  logic [3:0]  m_alias [32];

  reg_alias_file #(.REG_NUM(32), .DATA_W(32), .ROB_ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs1_alias(rs1_alias), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_alias(rs2_alias), .rs2_val(rs2_val),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_id(rename_id),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_alias(commit_alias)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0;
    rename_en = 1'b0; rename_rd = 5'd0; rename_id = 4'd1;
    commit_en = 1'b0; commit_rd = 5'd0; commit_val = 32'd0; commit_alias = 4'd1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0;
      m_alias[i] = 4'd0;
    end
  endtask

  // Reference update from the architectural rules, applied at each edge.
  task automatic tick();
    logic [3:0] nxt [32];
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (rdy) begin
      for (int i = 0; i < 32; i++) nxt[i] = m_alias[i];
      if (commit_en && commit_rd != 5'd0) begin
        m_val[commit_rd] = commit_val;
        if (m_alias[commit_rd] == commit_alias) nxt[commit_rd] = 4'd0;
      end
      if (rename_en && rename_rd != 5'd0 && !rollback) nxt[rename_rd] = rename_id;
      if (rollback) for (int i = 0; i < 32; i++) nxt[i] = 4'd0;
      for (int i = 0; i < 32; i++) m_alias[i] = nxt[i];
    end
    #1;
  endtask

  function automatic logic [36:0] model_query(input logic [4:0] idx);
    logic        b;
    logic [3:0]  a;
    logic [31:0] v;
    b = 1'b0; a = 4'd0; v = 32'd0;
    if (idx != 5'd0) begin
      b = (m_alias[idx] != 4'd0); a = m_alias[idx]; v = m_val[idx];
`ifdef COMMIT_FORWARD_EN
      if (commit_en && commit_rd == idx && m_alias[idx] == commit_alias && !rollback) begin
        b = 1'b0; a = 4'd0; v = commit_val;
      end
`endif
    end
    return {b, a, v};
  endfunction

  task automatic test_reset();
    idle();
    rename_en = 1'b1; rename_rd = 5'd5; rename_id = 4'd6;
    commit_en = 1'b1; commit_rd = 5'd9; commit_val = 32'h1234; commit_alias = 4'd2;
    tick();
    idle();
    rst_n = 1'b0;
    model_clear();
    rs1_idx = 5'd5; rs2_idx = 5'd9;
    #2;
    vectors++;
    if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0 || rs1_val !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_x5: got busy=%0b alias=%0d val=%h, required 0/0/0", rs1_busy, rs1_alias, rs1_val);
    end
    vectors++;
    if (rs2_val !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_x9: got val=%h, required 0", rs2_val);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rename();
    idle();
    rename_en = 1'b1; rename_rd = 5'd5; rename_id = 4'd3;
    rs1_idx = 5'd5;
    #2;
    vectors++;
    if (rs1_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rename_same_cycle_x5: got busy=%0b, required 0", rs1_busy);
    end
    tick();
    idle();
    rename_en = 1'b1; rename_rd = 5'd6; rename_id = 4'd2;
    rs2_idx = 5'd6;
    #2;
    vectors++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd3) begin
      miscompares++;
      $display("FAIL rename_x5: got busy=%0b alias=%0d, required 1/3", rs1_busy, rs1_alias);
    end
    vectors++;
    if (rs2_busy !== 1'b0 || rs2_alias !== 4'd0) begin
      miscompares++;
      $display("FAIL rename_same_cycle_x6: got busy=%0b alias=%0d, required 0/0", rs2_busy, rs2_alias);
    end
    tick();
    idle();
    #2;
    vectors++;
    if (rs2_busy !== 1'b1 || rs2_alias !== 4'd2) begin
      miscompares++;
      $display("FAIL rename_x6: got busy=%0b alias=%0d, required 1/2", rs2_busy, rs2_alias);
    end
  endtask

  task automatic test_matching_commit();
    idle();
    commit_en = 1'b1; commit_rd = 5'd5; commit_alias = 4'd3; commit_val = 32'hDEADBEEF;
    tick();
    idle();
    rs1_idx = 5'd5;
    #2;
    vectors++;
    if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0 || rs1_val !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL matching_commit: got busy=%0b alias=%0d val=%h, required 0/0/deadbeef", rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_stale_commit();
    idle();
    rename_en = 1'b1; rename_rd = 5'd5; rename_id = 4'd7;
    tick();
    idle();
    commit_en = 1'b1; commit_rd = 5'd5; commit_alias = 4'd3; commit_val = 32'h11;
    tick();
    idle();
    rs1_idx = 5'd5;
    #2;
    vectors++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd7 || rs1_val !== 32'h11) begin
      miscompares++;
      $display("FAIL stale_commit: got busy=%0b alias=%0d val=%h, required 1/7/11", rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_collision();
    idle();
    rename_en = 1'b1; rename_rd = 5'd5; rename_id = 4'd9;
    commit_en = 1'b1; commit_rd = 5'd5; commit_alias = 4'd9; commit_val = 32'h22;
    tick();
    idle();
    rs1_idx = 5'd5;
    #2;
    vectors++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd9 || rs1_val !== 32'h22) begin
      miscompares++;
      $display("FAIL collision: got busy=%0b alias=%0d val=%h, required 1/9/22", rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_forward();
    idle();
    rename_en = 1'b1; rename_rd = 5'd5; rename_id = 4'd3;
    tick();
    idle();
    commit_en = 1'b1; commit_rd = 5'd5; commit_alias = 4'd3; commit_val = 32'h55;
    rs1_idx = 5'd5;
    #2;
    vectors++;
`ifdef COMMIT_FORWARD_EN
    if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0 || rs1_val !== 32'h55) begin
      miscompares++;
      $display("FAIL forward: got busy=%0b alias=%0d val=%h, required 0/0/55", rs1_busy, rs1_alias, rs1_val);
    end
`else
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd3 || rs1_val !== 32'h22) begin
      miscompares++;
      $display("FAIL no_forward: got busy=%0b alias=%0d val=%h, required 1/3/22", rs1_busy, rs1_alias, rs1_val);
    end
`endif
    tick();
    idle();
    #2;
    vectors++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'h55) begin
      miscompares++;
      $display("FAIL forward_after: got busy=%0b val=%h, required 0/55", rs1_busy, rs1_val);
    end
  endtask

  task automatic test_rollback();
    for (int i = 1; i <= 3; i++) begin
      idle();
      rename_en = 1'b1; rename_rd = 5'(i); rename_id = 4'(i);
      tick();
    end
    idle();
    rollback = 1'b1;
    commit_en = 1'b1; commit_rd = 5'd4; commit_alias = 4'd12; commit_val = 32'h44;
    rename_en = 1'b1; rename_rd = 5'd7; rename_id = 4'd5;
    tick();
    idle();
    for (int i = 1; i <= 7; i++) begin
      rs1_idx = 5'(i);
      #1;
      vectors++;
      if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0) begin
        miscompares++;
        $display("FAIL rollback_x%0d: got busy=%0b alias=%0d, required 0/0", i, rs1_busy, rs1_alias);
      end
    end
    rs2_idx = 5'd4;
    #1;
    vectors++;
    if (rs2_val !== 32'h44) begin
      miscompares++;
      $display("FAIL rollback_commit_x4: got val=%h, required 44", rs2_val);
    end
    tick();
  endtask

  task automatic test_x0_freeze();
    idle();
    rename_en = 1'b1; rename_rd = 5'd0; rename_id = 4'd4;
    commit_en = 1'b1; commit_rd = 5'd0; commit_alias = 4'd0; commit_val = 32'hFF;
    rs1_idx = 5'd0;
    tick();
    #1;
    vectors++;
    if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0 || rs1_val !== 32'd0) begin
      miscompares++;
      $display("FAIL x0: got busy=%0b alias=%0d val=%h, required 0/0/0", rs1_busy, rs1_alias, rs1_val);
    end
    idle();
    rdy = 1'b0;
    commit_en = 1'b1; commit_rd = 5'd8; commit_alias = 4'd1; commit_val = 32'h88;
    rename_en = 1'b1; rename_rd = 5'd8; rename_id = 4'd4;
    tick();
    tick();
    idle();
    rs2_idx = 5'd8;
    #2;
    vectors++;
    if (rs2_busy !== 1'b0 || rs2_val !== 32'd0) begin
      miscompares++;
      $display("FAIL freeze_x8: got busy=%0b val=%h, required 0/0", rs2_busy, rs2_val);
    end
  endtask

  task automatic test_random();
    logic [36:0] e1, e2;
    for (int n = 0; n < 600; n++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      rollback  = ($urandom_range(0, 24) == 0);
      rename_en = ($urandom_range(0, 1) == 1);
      rename_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rename_id = 4'($urandom_range(1, 15));
      commit_en = ($urandom_range(0, 1) == 1);
      commit_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      commit_val = $urandom;
      if ($urandom_range(0, 1) == 1 && m_alias[commit_rd] != 4'd0) commit_alias = m_alias[commit_rd];
      else commit_alias = 4'($urandom_range(1, 15));
      rs1_idx = ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom_range(0, 7));
      rs2_idx = 5'($urandom_range(0, 31));
      #2;
      e1 = model_query(rs1_idx);
      e2 = model_query(rs2_idx);
      vectors++;
      if ({rs1_busy, rs1_alias, rs1_val} !== e1) begin
        miscompares++;
        $display("FAIL random_rs1 n=%0d idx=%0d: got %0b/%0d/%h, required %0b/%0d/%h", n, rs1_idx,
                 rs1_busy, rs1_alias, rs1_val, e1[36], e1[35:32], e1[31:0]);
      end
      vectors++;
      if ({rs2_busy, rs2_alias, rs2_val} !== e2) begin
        miscompares++;
        $display("FAIL random_rs2 n=%0d idx=%0d: got %0b/%0d/%h, required %0b/%0d/%h", n, rs2_idx,
                 rs2_busy, rs2_alias, rs2_val, e2[36], e2[35:32], e2[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    idle();
    rst_n = 1'b0;
    rs1_idx = 5'd0; rs2_idx = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_rename();
    test_matching_commit();
    test_stale_commit();
    test_collision();
    test_forward();
    test_rollback();
    test_x0_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_alias_file.md
Name: reg_alias_file

Overview:
- Architectural register file with per-register rename tags. It is the receiving end of the ROB commit interface and the source of rename state for the dispatcher.
- Holds 32 x 32-bit values plus one ROB-id alias per register. Alias 0 means the value is architectural and valid.
- Dispatcher queries rs1/rs2 and claims rd. ROB commits retire values and clear matching aliases. A rollback wipes all aliases.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired to zero.
- DATA_W, 32, register value width.
- ROB_ID_W, 4, alias width; id 0 is reserved as "no alias", valid ids are 1..2^ROB_ID_W-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  ROB misprediction flush.
- rs1_idx  in  5  dispatcher query, source 1.
- rs2_idx  in  5  dispatcher query, source 2.
- rs1_busy  out  1  rs1 has a live alias.
- rs1_alias  out  ROB_ID_W  alias of rs1; 0 if not busy.
- rs1_val  out  DATA_W  committed value of rs1.
- rs2_busy / rs2_alias / rs2_val  out  1 / ROB_ID_W / DATA_W  same as rs1, for rs2.
- rename_en  in  1  dispatcher issues an instruction writing rd.
- rename_rd  in  5  destination register.
- rename_id  in  ROB_ID_W  ROB entry (tail) allocated to it.
- commit_en  in  1  ROB commit valid (ROB res_rdy_2reg).
- commit_rd  in  5  ROB regidx_2regfile.
- commit_val  in  DATA_W  ROB res_2reg.
- commit_alias  in  ROB_ID_W  ROB reg_alias (committing entry id).

Behaviour:
- Reset: on rst_n low, asynchronously set all val[i]=0 and alias[i]=0. All query outputs then read busy=0, alias=0, val=0.
- rdy low: no register or alias changes; query outputs remain combinational on current state.
- Query outputs are purely combinational from current state (zero latency) and reflect state before this cycle's edge.
  - A same-cycle rename of the queried register is NOT visible. This is required so that "add x1,x1,x2" reads the old x1 alias.
- Index 0 always returns busy=0, alias=0, val=0. Writes and renames to rd=0 are ignored.
- Rename: rename_en && rename_rd!=0 && !rollback -> alias[rename_rd] <= rename_id next edge. rename_id==0 is illegal (assertion).
- Commit: commit_en && commit_rd!=0 -> val[commit_rd] <= commit_val next edge, unconditionally.
  - alias[commit_rd] <= 0 only if alias[commit_rd]==commit_alias. A younger rename has ownership and keeps its alias.
- Simultaneous rename and commit to the same rd: the value is written and alias <= rename_id. Rename wins.
- Rollback: all alias <= 0 next edge; values are retained. A commit in the same cycle still writes its value, because the ROB raises the commit and the rollback on the same edge. Rename in the same cycle is dropped.
- Alias wrap-around: ids are reused by the ROB. Matching is by exact id equality only. The ROB guarantees that no two live entries share an id.
- No handshake back-pressure: every commit and rename presented is accepted in the same cycle.

Optional Feature:
- Macro COMMIT_FORWARD_EN.
- Defined: a same-cycle commit is forwarded to queries. If commit_en && commit_rd==rsN_idx!=0 && alias[rsN_idx]==commit_alias && !rollback, then rsN_busy=0, rsN_alias=0, rsN_val=commit_val.
  - If the alias does not match, there is no forwarding: a younger producer is still pending.
- Undefined: queries return stored state only. A register whose producer commits this cycle still reads busy=1 with an alias the ROB has already cleared. The dispatcher must stall one cycle and re-query.

Test Plan:
- Reset and rename: assert rst_n=0 mid-run, then release; query x5 -> busy=0, val=0. Rename x5 with id 3; next cycle query x5 -> busy=1, alias=3.
- Matching commit: alias[x5]=3; commit rd=5, alias=3, val=0xDEADBEEF -> next cycle busy=0, val=0xDEADBEEF.
- Stale commit: alias[x5]=7; commit rd=5, alias=3, val=0x11 -> val=0x11, alias remains 7, busy=1.
- Same-cycle collision: rename x5 with id 9 and commit rd=5, alias=9, val=0x22 in the same cycle -> alias=9, val=0x22. Separately, rename x6 and query x6 in the same cycle -> query shows pre-rename state.
- Rollback: rename x1, x2, x3 with ids 1..3, then rollback with a commit to rd=4, val=0x44 and a rename of x7 in the same cycle -> all busy=0, x4=0x44, x7 not renamed.
- x0 and freeze: rename or commit to rd=0 -> x0 reads 0, not busy. With rdy=0, a commit to x8 has no effect.
- Forwarding: with COMMIT_FORWARD_EN, alias[x5]=3; commit alias 3, val=0x55 and query x5 in the same cycle -> busy=0, val=0x55. Without the macro, the same cycle reads busy=1, alias=3.
